// File: rtl/sram_arbiter.sv
// sram_arbiter: arbitrates an inst and a data requester onto one SRAM port with one-cycle read latency.
// Define SRAM_ARB_ROUND_ROBIN_EN to alternate contended grants instead of fixed data-over-inst priority.
module sram_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [3:0]        i_wen,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic [3:0]        d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [31:0]       d_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;

    owner_t owner_q, owner_d;
    logic   grant_i, grant_d;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic prefer_inst_q, prefer_inst_d;

    // The pointer only moves on contention, so uncontested traffic never disturbs the fairness order.
    always_comb begin
        grant_i       = ~rst & i_req & (~d_req | prefer_inst_q);
        grant_d       = ~rst & d_req & (~i_req | ~prefer_inst_q);
        prefer_inst_d = (~rst & i_req & d_req) ? ~prefer_inst_q : prefer_inst_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prefer_inst_q <= 1'b1;
        else     prefer_inst_q <= prefer_inst_d;
    end
`else
    always_comb begin
        grant_d = ~rst & d_req;
        grant_i = ~rst & i_req & ~d_req;
    end
`endif

    always_comb begin
        i_addr_ok = grant_i;
        d_addr_ok = grant_d;
        ram_en    = grant_i | grant_d;
        ram_wen   = grant_d ? d_wen : grant_i ? i_wen : 4'b0000;
        ram_addr  = grant_i ? i_addr : d_addr;
        ram_wdata = grant_i ? i_wdata : d_wdata;
        owner_d   = grant_d ? OWN_DATA : grant_i ? OWN_INST : OWN_NONE;
        i_data_ok = owner_q == OWN_INST;
        d_data_ok = owner_q == OWN_DATA;
        i_rdata   = i_data_ok ? ram_rdata : 32'h0;
        d_rdata   = d_data_ok ? ram_rdata : 32'h0;
    end

    // Asynchronous clear kills a response still in flight when reset arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) owner_q <= OWN_NONE;
        else     owner_q <= owner_d;
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and randomized checks of sram_arbiter against a transaction-level model.
module tb_sram_arbiter;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req;
    logic [3:0]    i_wen, d_wen;
    logic [AW-1:0] i_addr, d_addr;
    logic [31:0]   i_wdata, d_wdata;
    logic          i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0]   i_rdata, d_rdata;
    logic          ram_en;
    logic [3:0]    ram_wen;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;

    int checks = 0, errors = 0;
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    int          own, last_win;
    logic        own_read, prefer_inst;
    logic [31:0] own_rd;
    logic [1:0]  obs_grant;
    logic        obs_i_dok, obs_d_dok;
    logic [31:0] obs_i_rdata, obs_d_rdata;
    logic        i_pend, d_pend;

    sram_arbiter #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wen(i_wen), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= mem[ram_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    function automatic logic [31:0] init_val(input int k);
        return 32'h5A00_0000 + k * 32'h0001_0203;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: predict the winner from the arbitration rules, check outputs mid-cycle, then retire.
    task automatic cyc();
        int          win;
        logic        pick_inst;
        logic [3:0]  w;
        logic [31:0] a, wd;
        @(negedge clk);
        if (rst) own = 0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        pick_inst = prefer_inst;
`else
        pick_inst = 1'b0;
`endif
        win = rst ? 0 : (i_req && d_req) ? (pick_inst ? 1 : 2) : d_req ? 2 : i_req ? 1 : 0;
        w  = (win == 1) ? i_wen : d_wen;
        a  = (win == 1) ? i_addr : d_addr;
        wd = (win == 1) ? i_wdata : d_wdata;
        obs_grant   = {i_addr_ok, d_addr_ok};
        obs_i_dok   = i_data_ok;
        obs_d_dok   = d_data_ok;
        obs_i_rdata = i_rdata;
        obs_d_rdata = d_rdata;
        chk("i_addr_ok", i_addr_ok, win == 1);
        chk("d_addr_ok", d_addr_ok, win == 2);
        chk("ram_en", ram_en, win != 0);
        chk("ram_wen", ram_wen, win != 0 ? w : 4'h0);
        if (win != 0) begin
            chk("ram_addr", ram_addr, a);
            chk("ram_wdata", ram_wdata, wd);
        end
        chk("i_data_ok", i_data_ok, own == 1);
        chk("d_data_ok", d_data_ok, own == 2);
        if (own == 1 && own_read) chk("i_rdata", i_rdata, own_rd);
        else if (own != 1)        chk("i_rdata_zero", i_rdata, 0);
        if (own == 2 && own_read) chk("d_rdata", d_rdata, own_rd);
        else if (own != 2)        chk("d_rdata_zero", d_rdata, 0);
        @(posedge clk);
        if (rst) begin
            own = 0;
            prefer_inst = 1'b1;
        end else begin
            if (win != 0 && w == 4'h0) own_rd = ref_mem[a[7:2]];
            for (int b = 0; b < 4; b++)
                if (win != 0 && w[b]) ref_mem[a[7:2]][8*b +: 8] = wd[8*b +: 8];
            if (i_req && d_req) prefer_inst = (win == 2);
            own = win;
            own_read = (w == 4'h0);
        end
        last_win = win;
        #1;
    endtask

    task automatic drive_i(input logic req, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        i_req = req; i_wen = wen; i_addr = addr; i_wdata = wdata;
    endtask

    task automatic drive_d(input logic req, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        d_req = req; d_wen = wen; d_addr = addr; d_wdata = wdata;
    endtask

    initial begin
        for (int k = 0; k < 64; k++) begin
            mem[k] = init_val(k);
            ref_mem[k] = init_val(k);
        end
        own = 0; own_read = 1'b0; own_rd = 32'h0; prefer_inst = 1'b1; last_win = 0;
        ram_rdata = 32'h0;
        rst = 1'b1;
        drive_i(1'b1, 4'h0, 32'h40, 32'h1111_1111);
        drive_d(1'b1, 4'h0, 32'h44, 32'h2222_2222);
        cyc();
        cyc();
        chk("rst_no_grant", obs_grant, 2'b00);

        // Contention held for four cycles right after reset.
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            chk("rr_grant", obs_grant, (k % 2 == 0) ? 2'b10 : 2'b01);
`else
            chk("fixed_grant", obs_grant, 2'b01);
`endif
        end
        drive_i(1'b0, 4'h0, 32'h0, 32'h0);
        drive_d(1'b0, 4'h0, 32'h0, 32'h0);
        cyc();

        drive_d(1'b1, 4'h0, 32'h10, 32'h0);
        cyc();
        chk("read10_grant", obs_grant, 2'b01);
        drive_d(1'b0, 4'h0, 32'h0, 32'h0);
        cyc();
        chk("read10_dok", obs_d_dok, 1'b1);
        chk("read10_rdata", obs_d_rdata, init_val(4));

        drive_d(1'b1, 4'hF, 32'h20, 32'hDEAD_BEEF);
        cyc();
        drive_d(1'b0, 4'h0, 32'h0, 32'h0);
        drive_i(1'b1, 4'h0, 32'h20, 32'h0);
        cyc();
        drive_i(1'b0, 4'h0, 32'h0, 32'h0);
        cyc();
        chk("raw_i_dok", obs_i_dok, 1'b1);
        chk("raw_i_rdata", obs_i_rdata, 32'hDEAD_BEEF);

        // Reset arriving in the cycle after a grant must swallow its response.
        drive_d(1'b1, 4'h0, 32'h30, 32'h0);
        cyc();
        drive_d(1'b0, 4'h0, 32'h0, 32'h0);
        rst = 1'b1;
        cyc();
        chk("rst_kill_dok", obs_d_dok, 1'b0);
        chk("rst_kill_rdata", obs_d_rdata, 32'h0);
        rst = 1'b0;
        cyc();

        i_pend = 1'b0;
        d_pend = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (last_win == 1) i_pend = 1'b0;
            if (last_win == 2) d_pend = 1'b0;
            if (i_pend && $urandom_range(0, 9) == 0) i_pend = 1'b0;
            else if (!i_pend && $urandom_range(0, 2) != 0) begin
                i_pend = 1'b1;
                drive_i(1'b1, $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0,
                        32'($urandom_range(0, 63)) << 2, $urandom);
            end
            if (d_pend && $urandom_range(0, 9) == 0) d_pend = 1'b0;
            else if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend = 1'b1;
                drive_d(1'b1, $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0,
                        32'($urandom_range(0, 63)) << 2, $urandom);
            end
            i_req = i_pend;
            d_req = d_pend;
            cyc();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the width of the address on both requester ports and on the RAM port.
REQ-002 SHALL have port clk, input, 1, the single clock; every register samples on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have inst requester inputs i_req (1, request), i_wen (4, byte write enables), i_addr (ADDR_W) and i_wdata (32).
REQ-005 SHALL have inst requester outputs i_addr_ok (1, request accepted), i_data_ok (1, response valid) and i_rdata (32).
REQ-006 SHALL have data requester ports d_req, d_wen, d_addr, d_wdata, d_addr_ok, d_data_ok and d_rdata, with directions and widths as in REQ-004/005.
REQ-007 SHALL have RAM outputs ram_en (1), ram_wen (4), ram_addr (ADDR_W) and ram_wdata (32), and RAM input ram_rdata (32); the RAM returns read data one cycle after ram_en.

Function
REQ-008 SHALL grant at most one requester per cycle, using combinational arbitration on the current i_req/d_req.
REQ-009 SHALL, when exactly one requester has req=1, grant that requester.
REQ-010 SHALL, when both requesters have req=1, grant the data requester (fixed priority), except as set by REQ-021.
REQ-011 SHALL, in the grant cycle, drive ram_en=1 and drive ram_wen/ram_addr/ram_wdata from the winner, combinationally.
REQ-012 SHALL assert x_addr_ok=1 only for the winner and only in the grant cycle; the loser sees addr_ok=0 and holds its request.
REQ-013 SHALL, with no grant, drive ram_en=0 and ram_wen=4'b0000; ram_addr and ram_wdata are don't-care.
REQ-014 SHALL keep a response-owner register (NONE/INST/DATA) loaded with the winner at each grant, or NONE when there is no grant.
REQ-015 SHALL assert x_data_ok=1 for exactly one cycle, in the cycle after x's grant, for reads and writes alike.
REQ-016 SHALL drive x_rdata=ram_rdata when the owner is x, and 0 otherwise.
REQ-017 SHALL sustain one grant per cycle; a grant in cycle N+1 overlaps the response of the grant in cycle N.
REQ-018 SHALL treat a requester that drops req before addr_ok as aborted: no RAM access and no data_ok.
REQ-019 SHALL never assert i_addr_ok and d_addr_ok in the same cycle, nor i_data_ok and d_data_ok in the same cycle.

Reset
REQ-020 SHALL, while rst=1: owner=NONE, round-robin pointer=INST-first, ram_en=0, ram_wen=0, both addr_ok=0, both data_ok=0, both rdata=0; a grant made in the cycle before rst rises SHALL produce no data_ok.

Configuration
REQ-021 SHALL implement macro SRAM_ARB_ROUND_ROBIN_EN:
- defined: on contention, grant the requester not granted at the most recent contention; a 1-bit pointer updates only on contended grants; the first contention after reset goes to inst.
- undefined: fixed data-over-inst priority; no pointer register.

Verification
REQ-022 SHALL cover: d_req=1 read at addr 0x10, i_req=0 -> d_addr_ok=1, ram_addr=0x10, ram_wen=0 in cycle N; d_data_ok=1 and d_rdata=RAM[0x10] in cycle N+1.
REQ-023 SHALL cover: i_req and d_req both held 1 for 4 cycles, macro undefined -> data granted in all 4 cycles, i_addr_ok=0 throughout.
REQ-024 SHALL cover: same stimulus as REQ-023 with the macro defined -> grants alternate I,D,I,D and data_ok alternates the following cycles.
REQ-025 SHALL cover: d write of 0xDEADBEEF to 0x20 with wen=4'b1111, then i read of 0x20 next cycle -> i_rdata=0xDEADBEEF and i_data_ok=1 two cycles after the write grant.
REQ-026 SHALL cover: grant in cycle N, rst pulsed during cycle N+1 -> no data_ok, ram_en=0, all outputs at reset values.
